// File: rtl/btb_pkg.sv
// -----------------------------------------------------------------------------
// btb_pkg
// Shared constants and types for the jump_lookup_btb branch-target buffer.
//   CNT_W          width of the 2-bit direction counter
//   CNT_STRONG_NT  counter floor (strongly not-taken)
//   CNT_WEAK_T     value loaded into a freshly allocated entry
//   CNT_MAX        counter ceiling (strongly taken)
//   BTB_PC_W       default PC / target width
//   btb_entry_t    packed entry layout {valid, tag, target, cnt} at BTB_PC_W
// -----------------------------------------------------------------------------
package btb_pkg;

   localparam int CNT_W = 2;

   localparam logic [CNT_W-1:0] CNT_STRONG_NT = 2'b00;
   localparam logic [CNT_W-1:0] CNT_WEAK_T    = 2'b10;
   localparam logic [CNT_W-1:0] CNT_MAX       = 2'b11;

   localparam int BTB_PC_W = 8;

   // Entry layout at the default PC width. The top level declares the same
   // layout at its own PC_W so the field order stays identical.
   typedef struct packed {
      logic                valid;
      logic [BTB_PC_W-1:0] tag;
      logic [BTB_PC_W-1:0] target;
      logic [CNT_W-1:0]    cnt;
   } btb_entry_t;

endpackage : btb_pkg

// File: rtl/btb_sat_counter.sv
// -----------------------------------------------------------------------------
// btb_sat_counter
// Next-state function of a 2-bit saturating up/down direction counter.
// Purely combinational; the owning entry holds the state.
//   cnt_i  current counter value
//   en_i   1 = step the counter this cycle, 0 = hold
//   up_i   1 = count up (taken), 0 = count down (not taken)
//   cnt_o  next counter value, clamped to [CNT_STRONG_NT, CNT_MAX]
// -----------------------------------------------------------------------------
module btb_sat_counter
   import btb_pkg::*;
(
   input  logic [CNT_W-1:0] cnt_i,
   input  logic             en_i,
   input  logic             up_i,
   output logic [CNT_W-1:0] cnt_o
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   always_comb begin
      // NOTE: cnt_o gets a default before any branch so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      cnt_o = cnt_i;
      if (en_i) begin
         if (up_i) begin
            if (cnt_i != CNT_MAX) cnt_o = cnt_i + CNT_ONE;
         end else begin
            if (cnt_i != CNT_STRONG_NT) cnt_o = cnt_i - CNT_ONE;
         end
      end
   end

endmodule : btb_sat_counter

// File: rtl/jump_lookup_btb.sv
// -----------------------------------------------------------------------------
// jump_lookup_btb
// Fully associative branch-target buffer with 2-bit direction counters.
// Fetch looks up a PC combinationally; execute writes back resolved jumps.
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   lk_pc         fetch PC to look up
//   pred_hit      lk_pc matches a valid entry (combinational)
//   pred_taken    counter MSB of the matching entry, 0 on miss
//   pred_target   stored target of the matching entry, 0 on miss
//   pred_index    matching entry index, 0 on miss
//   upd_valid     resolved jump update this cycle
//   upd_pc        PC of the resolved jump
//   upd_taken     actual direction
//   upd_target    actual target
//   flush         invalidate every entry (wins over a same-cycle update)
//   entry_count   registered number of valid entries
//   mispredict    registered pulse: update contradicted the stored prediction
// -----------------------------------------------------------------------------
module jump_lookup_btb
   import btb_pkg::*;
#(
   parameter  int PC_W    = BTB_PC_W,
   parameter  int ENTRIES = 4,
   localparam int IDX_W   = $clog2(ENTRIES)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PC_W-1:0]   lk_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [PC_W-1:0]   pred_target,
   output logic [IDX_W-1:0]  pred_index,
   input  logic              upd_valid,
   input  logic [PC_W-1:0]   upd_pc,
   input  logic              upd_taken,
   input  logic [PC_W-1:0]   upd_target,
   input  logic              flush,
   output logic [IDX_W:0]    entry_count,
   output logic              mispredict
);

   localparam int CNTR_W = IDX_W + 1;

   typedef struct packed {
      logic              valid;
      logic [PC_W-1:0]   tag;
      logic [PC_W-1:0]   target;
      logic [CNT_W-1:0]  cnt;
   } entry_t;

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   entry_t             entries_q [ENTRIES];
   entry_t             entries_d [ENTRIES];
   logic [IDX_W-1:0]   alloc_ptr_q,   alloc_ptr_d;
   logic [CNTR_W-1:0]  entry_count_q, entry_count_d;
   logic               mispredict_q,  mispredict_d;

   // ---------------------------------------------------------------------
   // Per-entry CAM match and counter next-state
   // ---------------------------------------------------------------------
   logic [ENTRIES-1:0] lk_match;
   logic [ENTRIES-1:0] upd_match;
   logic [ENTRIES-1:0] invalid_vec;
   logic [CNT_W-1:0]   cnt_next [ENTRIES];

   for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      assign lk_match[gi]    = entries_q[gi].valid && (entries_q[gi].tag == lk_pc);
      assign upd_match[gi]   = entries_q[gi].valid && (entries_q[gi].tag == upd_pc);
      assign invalid_vec[gi] = !entries_q[gi].valid;

      btb_sat_counter u_cnt (
         .cnt_i (entries_q[gi].cnt),
         .en_i  (upd_match[gi]),
         .up_i  (upd_taken),
         .cnt_o (cnt_next[gi])
      );
   end

   // ---------------------------------------------------------------------
   // Lookup: at most one entry matches, so the last-match loop simply
   // selects it; the registered state means no bypass from this cycle's
   // update.
   // ---------------------------------------------------------------------
   always_comb begin
      pred_hit    = |lk_match;
      pred_taken  = 1'b0;
      pred_target = '0;
      pred_index  = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (lk_match[i]) begin
            pred_taken  = entries_q[i].cnt[CNT_W-1];
            pred_target = entries_q[i].target;
            pred_index  = IDX_W'(i);
         end
      end
   end

   // ---------------------------------------------------------------------
   // Update-side match result and victim selection
   // ---------------------------------------------------------------------
   logic             upd_hit;
   logic             upd_hit_msb;
   logic             any_invalid;
   logic [IDX_W-1:0] first_invalid;
   logic [IDX_W-1:0] victim;

   always_comb begin
      upd_hit     = |upd_match;
      upd_hit_msb = 1'b0;
      for (int i = 0; i < ENTRIES; i++) begin
         if (upd_match[i]) upd_hit_msb = entries_q[i].cnt[CNT_W-1];
      end

      // Scanning downward leaves the lowest-index invalid entry selected.
      any_invalid   = |invalid_vec;
      first_invalid = '0;
      for (int i = ENTRIES - 1; i >= 0; i--) begin
         if (invalid_vec[i]) first_invalid = IDX_W'(i);
      end

      victim = any_invalid ? first_invalid : alloc_ptr_q;
   end

   // ---------------------------------------------------------------------
   // Next-state
   // ---------------------------------------------------------------------
   always_comb begin
      entries_d    = entries_q;
      alloc_ptr_d  = alloc_ptr_q;
      mispredict_d = 1'b0;

      if (flush) begin
         // Only valid bits and the pointer are cleared; stale tags and
         // counters are harmless behind valid=0.
         for (int i = 0; i < ENTRIES; i++) entries_d[i].valid = 1'b0;
         alloc_ptr_d = '0;
      end else if (upd_valid) begin
         if (upd_hit) begin
            for (int i = 0; i < ENTRIES; i++) begin
               if (upd_match[i]) begin
                  entries_d[i].cnt = cnt_next[i];
                  if (upd_taken) entries_d[i].target = upd_target;
               end
            end
            mispredict_d = (upd_hit_msb != upd_taken);
         end else if (upd_taken) begin
            entries_d[victim] = '{valid: 1'b1, tag: upd_pc, target: upd_target,
                                  cnt: CNT_WEAK_T};
            // ENTRIES is a power of two, so the natural IDX_W-bit wrap is
            // the modulo-ENTRIES increment.
            if (!any_invalid) alloc_ptr_d = alloc_ptr_q + IDX_W'(1);
            mispredict_d = 1'b1;
         end
      end

      // Popcount of the post-edge valid bits.
      entry_count_d = '0;
      for (int i = 0; i < ENTRIES; i++) begin
         entry_count_d = entry_count_d + CNTR_W'(entries_d[i].valid);
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   // NOTE: the entry array is reset along with the control flops because a
   // reset must leave tags, targets and counters at zero, not just valids;
   // all state updates use non-blocking assignment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
         alloc_ptr_q   <= '0;
         entry_count_q <= '0;
         mispredict_q  <= 1'b0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) entries_q[i] <= entries_d[i];
         alloc_ptr_q   <= alloc_ptr_d;
         entry_count_q <= entry_count_d;
         mispredict_q  <= mispredict_d;
      end
   end

   assign entry_count = entry_count_q;
   assign mispredict  = mispredict_q;

endmodule : jump_lookup_btb

// File: tb/tb_jump_lookup_btb.sv
// -----------------------------------------------------------------------------
// tb_jump_lookup_btb
// Scoreboard bench for jump_lookup_btb. A driver issues one transaction per
// cycle and pushes the expected lookup result (due before the next edge) and
// the expected registered result (due after it) into a queue; a monitor on
// the falling edge pops and compares whatever has come due. Expectations
// come from a table model with plain search / min / max arithmetic.
// -----------------------------------------------------------------------------
module tb_jump_lookup_btb;

   localparam int PC_W    = 8;
   localparam int ENTRIES = 4;
   localparam int IDX_W   = 2;

   logic             clk;
   logic             rst_n;
   logic [PC_W-1:0]  lk_pc;
   logic             pred_hit;
   logic             pred_taken;
   logic [PC_W-1:0]  pred_target;
   logic [IDX_W-1:0] pred_index;
   logic             upd_valid;
   logic [PC_W-1:0]  upd_pc;
   logic             upd_taken;
   logic [PC_W-1:0]  upd_target;
   logic             flush;
   logic [IDX_W:0]   entry_count;
   logic             mispredict;

   jump_lookup_btb #(.PC_W(PC_W), .ENTRIES(ENTRIES)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .lk_pc       (lk_pc),
      .pred_hit    (pred_hit),
      .pred_taken  (pred_taken),
      .pred_target (pred_target),
      .pred_index  (pred_index),
      .upd_valid   (upd_valid),
      .upd_pc      (upd_pc),
      .upd_taken   (upd_taken),
      .upd_target  (upd_target),
      .flush       (flush),
      .entry_count (entry_count),
      .mispredict  (mispredict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------------
   // Counters and compare helper
   // ---------------------------------------------------------------------
   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model: a table of entries plus a replacement pointer
   // ---------------------------------------------------------------------
   int m_valid  [ENTRIES];
   int m_tag    [ENTRIES];
   int m_target [ENTRIES];
   int m_cnt    [ENTRIES];
   int m_ptr;

   function automatic void model_reset();
      for (int i = 0; i < ENTRIES; i++) begin
         m_valid[i] = 0; m_tag[i] = 0; m_target[i] = 0; m_cnt[i] = 0;
      end
      m_ptr = 0;
   endfunction

   function automatic int model_find(input int pc);
      for (int i = 0; i < ENTRIES; i++)
         if (m_valid[i] != 0 && m_tag[i] == pc) return i;
      return -1;
   endfunction

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < ENTRIES; i++) n += m_valid[i];
      return n;
   endfunction

   // Applies one clock edge of update/flush; returns the mispredict pulse.
   function automatic int model_update(input int uv, input int pc, input int tk,
                                       input int tgt, input int fl);
      int h, v;
      if (fl != 0) begin
         for (int i = 0; i < ENTRIES; i++) m_valid[i] = 0;
         m_ptr = 0;
         return 0;
      end
      if (uv == 0) return 0;
      h = model_find(pc);
      if (h >= 0) begin
         int mis = ((m_cnt[h] >= 2) ? 1 : 0) != tk;
         if (tk != 0) begin
            m_cnt[h]    = (m_cnt[h] + 1 > 3) ? 3 : m_cnt[h] + 1;
            m_target[h] = tgt;
         end else begin
            m_cnt[h] = (m_cnt[h] - 1 < 0) ? 0 : m_cnt[h] - 1;
         end
         return mis;
      end
      if (tk == 0) return 0;
      v = -1;
      for (int i = ENTRIES - 1; i >= 0; i--) if (m_valid[i] == 0) v = i;
      if (v < 0) begin
         v = m_ptr;
         m_ptr = (m_ptr + 1) % ENTRIES;
      end
      m_valid[v] = 1; m_tag[v] = pc; m_target[v] = tgt; m_cnt[v] = 2;
      return 1;
   endfunction

   // ---------------------------------------------------------------------
   // Scoreboard
   // ---------------------------------------------------------------------
   typedef struct {
      int kind;   // 0 = lookup result, 1 = registered result
      int due;    // falling-edge count at which it is compared
      int hit;
      int taken;
      int target;
      int index;
      int count;
      int mis;
   } exp_t;

   exp_t sb_q[$];

   always @(negedge clk) begin : monitor
      exp_t e;
      cyc++;
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
         e = sb_q.pop_front();
         if (e.kind == 0) begin
            check("pred_hit",    pred_hit,    e.hit);
            check("pred_taken",  pred_taken,  e.taken);
            check("pred_target", pred_target, e.target);
            check("pred_index",  pred_index,  e.index);
         end else begin
            check("mispredict",  mispredict,  e.mis);
            check("entry_count", entry_count, e.count);
         end
      end
   end

   // One transaction: inputs held from just after a rising edge through
   // the next one.
   task automatic step(input int lk, input int uv, input int pc, input int tk,
                       input int tgt, input int fl);
      exp_t e;
      int   h;
      @(posedge clk); #2;
      lk_pc      = PC_W'(lk);
      upd_valid  = uv[0];
      upd_pc     = PC_W'(pc);
      upd_taken  = tk[0];
      upd_target = PC_W'(tgt);
      flush      = fl[0];

      h = model_find(lk);
      e = '{kind: 0, due: cyc + 1, hit: (h >= 0) ? 1 : 0,
            taken: (h >= 0 && m_cnt[h] >= 2) ? 1 : 0,
            target: (h >= 0) ? m_target[h] : 0,
            index: (h >= 0) ? h : 0, count: 0, mis: 0};
      sb_q.push_back(e);

      e.kind  = 1;
      e.due   = cyc + 2;
      e.mis   = model_update(uv, pc, tk, tgt, fl);
      e.count = model_count();
      sb_q.push_back(e);
   endtask

   task automatic lookup(input int lk);
      step(lk, 0, 0, 0, 0, 0);
   endtask

   task automatic update(input int pc, input int tk, input int tgt);
      step(pc, 1, pc, tk, tgt, 0);
   endtask

   // Let the last transaction take its edge, then wait (bounded) for the
   // monitor to consume everything outstanding.
   task automatic drain();
      @(posedge clk); #2;
      upd_valid = 1'b0;
      flush     = 1'b0;
      for (int i = 0; i < 8 && sb_q.size() > 0; i++) @(negedge clk);
      check("scoreboard_drained", sb_q.size(), 0);
   endtask

   // Asynchronous reset pulse placed between clock edges.
   task automatic pulse_reset();
      @(posedge clk); #3;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk); #3;
      rst_n = 1'b1;
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      int h;
      rst_n      = 1'b0;
      lk_pc      = 8'h10;
      upd_valid  = 1'b0;
      upd_pc     = '0;
      upd_taken  = 1'b0;
      upd_target = '0;
      flush      = 1'b0;
      model_reset();

      // Reset state
      #12;
      check("rst_pred_hit",    pred_hit,    0);
      check("rst_pred_target", pred_target, 0);
      check("rst_pred_index",  pred_index,  0);
      check("rst_entry_count", entry_count, 0);
      check("rst_mispredict",  mispredict,  0);
      rst_n = 1'b1;

      // Allocate 8'h10 and look it up
      update(8'h10, 1, 8'h04);
      lookup(8'h10);

      // Counter saturation on 8'h10
      update(8'h10, 0, 8'hEE);
      update(8'h10, 0, 8'hEE);
      update(8'h10, 0, 8'hEE);
      lookup(8'h10);
      for (int i = 0; i < 4; i++) update(8'h10, 1, 8'h08);
      lookup(8'h10);
      update(8'h20, 0, 8'h99);
      lookup(8'h20);
      drain();

      // Replacement from reset: fifth allocation goes to index 0, sixth to 1
      pulse_reset();
      for (int p = 1; p <= 5; p++) update(p * 16, 1, p + 8'hA0);
      lookup(8'h50);
      lookup(8'h10);
      update(8'h60, 1, 8'hB6);
      lookup(8'h60);

      // Flush wins over a same-cycle update
      step(8'h30, 1, 8'h70, 1, 8'h11, 1);
      lookup(8'h70);
      lookup(8'h50);
      update(8'h80, 1, 8'hC8);
      lookup(8'h80);

      // Async reset mid-operation
      update(8'h50, 1, 8'h55);
      update(8'h60, 1, 8'h66);
      drain();
      @(posedge clk); #2;
      lk_pc = 8'h50;
      h = model_find(8'h50);
      #1;
      check("pre_reset_hit", pred_hit, (h >= 0) ? 1 : 0);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("async_reset_hit",   pred_hit,    0);
      check("async_reset_count", entry_count, 0);
      @(posedge clk); #3;
      rst_n = 1'b1;
      lookup(8'h50);
      drain();

      // Randomised traffic over a PC set larger than the table
      for (int n = 0; n < 600; n++) begin
         int lk, pc, tk, uv, fl;
         lk = $urandom_range(1, 7) * 16;
         pc = $urandom_range(1, 7) * 16;
         tk = ($urandom_range(0, 99) < 60) ? 1 : 0;
         uv = ($urandom_range(0, 3) != 0) ? 1 : 0;
         fl = ($urandom_range(0, 39) == 0) ? 1 : 0;
         step(lk, uv, pc, tk, $urandom_range(0, 255), fl);
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Absolute time limit so the bench always ends on its own.
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule : tb_jump_lookup_btb

// File: doc/jump_lookup_btb.md
Name: jump_lookup_btb

Overview:
- Parametrised branch-target buffer; successor to the fixed two-entry jump lookup table in processor_8085_pipeline.
- Fetch stage presents the PC and gets a same-cycle hit, taken prediction, target and entry index.
- Execute stage writes back the resolved jump outcome.
- Adds configurable depth and PC width, 2-bit saturating direction counters, first-invalid-then-round-robin allocation, and flush.

Parameters:
- PC_W, 8, width of PC and target fields.
- ENTRIES, 4, number of buffer entries; power of two, minimum 2.
- IDX_W, $clog2(ENTRIES), width of the entry index; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- lk_pc  in  PC_W  fetch PC to look up
- pred_hit  out  1  lk_pc matches a valid entry (combinational)
- pred_taken  out  1  counter MSB of the matching entry; 0 on miss
- pred_target  out  PC_W  stored target of the matching entry; 0 on miss
- pred_index  out  IDX_W  matching entry index; 0 on miss
- upd_valid  in  1  resolved jump update this cycle
- upd_pc  in  PC_W  PC of the resolved jump
- upd_taken  in  1  actual direction
- upd_target  in  PC_W  actual target
- flush  in  1  invalidate all entries
- entry_count  out  IDX_W+1  number of valid entries (registered)
- mispredict  out  1  registered pulse: the update contradicted the prediction the table held at update time

Behaviour:
- Reset (async, rst_n=0):
  - All valid bits, tags, targets and counters = 0; alloc pointer = 0; entry_count = 0; mispredict = 0.
  - pred_* outputs go to 0 immediately.
- Storage per entry: valid, tag[PC_W], target[PC_W], cnt[2].
- Lookup:
  - Fully associative, purely combinational on lk_pc against the registered state.
  - Multiple matches are impossible by construction (see duplicate rule).
  - No bypass: a same-cycle update to the same PC is not visible until the next cycle.
- Update:
  - Applied at the clk edge when upd_valid=1 and flush=0.
  - The block does its own CAM match on upd_pc and does not rely on fetch-time pred_index.
- Update hit (match on upd_pc):
  - upd_taken=1: cnt saturating-increments (max 3) and target <= upd_target.
  - upd_taken=0: cnt saturating-decrements (min 0); target unchanged.
  - mispredict <= (cnt[1] != upd_taken).
- Update miss, upd_taken=1 (allocate):
  - Victim = lowest-index invalid entry if any.
  - Otherwise victim = alloc pointer, and the pointer increments modulo ENTRIES (wraps ENTRIES-1 -> 0).
  - The pointer is not advanced when an invalid entry is used.
  - Victim gets valid=1, tag=upd_pc, target=upd_target, cnt=2'b10 (weakly taken).
  - mispredict <= 1.
- Update miss, upd_taken=0: no allocation; mispredict <= 0.
- Duplicate rule: a hit always updates in place; an allocation never creates a second entry with the same tag.
- Flush:
  - Synchronous; clears all valid bits and resets alloc pointer to 0.
  - Has priority over a same-cycle update, which is dropped (mispredict <= 0).
  - Tags, targets and counters may be left unchanged.
- mispredict is 0 in any cycle without an applied update.
- entry_count:
  - Popcount of valid bits, registered.
  - Saturates at ENTRIES by construction.
  - Reflects the post-edge state.
- Reset asserted mid-update: the update is lost and the state goes to reset values.

Decomposition:
- Package btb_pkg holds:
  - counter constants CNT_STRONG_NT=2'b00, CNT_WEAK_T=2'b10, CNT_MAX=2'b11;
  - the counter width constant;
  - a packed entry typedef {valid, tag, target, cnt} parametrised via PC_W.
- One sub-module, btb_sat_counter: a 2-bit saturating up/down next-state function, instantiated per entry.
- CAM match, victim select and popcount stay in the top level as generate loops.

Test Plan:
- Reset: hold rst_n=0 with lk_pc=8'h10 -> pred_hit=0, pred_target=8'h00, entry_count=0, mispredict=0.
- Allocate: upd_pc=8'h10, upd_taken=1, upd_target=8'h04 -> next cycle lk_pc=8'h10 gives pred_hit=1, pred_taken=1, pred_target=8'h04, pred_index=0, entry_count=1, mispredict pulse=1.
- Saturation on 8'h10:
  - Two not-taken updates -> cnt=0, pred_taken=0, pred_hit=1; the second update has mispredict=0.
  - A third not-taken update keeps cnt=0.
  - Four taken updates -> cnt=3.
  - A not-taken update with upd_pc=8'h20 (miss) -> no allocation, entry_count unchanged.
- Replacement: taken updates for 8'h10, 8'h20, 8'h30, 8'h40, 8'h50 from reset -> 8'h50 lands in index 0, lk_pc=8'h10 misses, entry_count stays 4; a further 8'h60 lands in index 1.
- Flush priority: flush=1 together with upd_valid for 8'h70 -> all lookups miss, entry_count=0, mispredict=0; next allocation goes to index 0.
- Async reset mid-operation: drop rst_n between clock edges while entries are valid -> pred_hit falls to 0 before the next edge; after release, lookup of 8'h50 misses.
